// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter among NREQ requesters,
// with packet locking on non-LAST bytes and an idle lock timeout.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 255,
  parameter int TW           = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_LAST,
  output logic [NREQ-1:0]   ACK,
  output logic [NREQ-1:0]   GRANT,
  output logic              LOCKED,
  output logic              TX_START,
  output logic [7:0]        TX_DATA,
  input  logic              TX_BUSY,
  output logic [1:0]        DBG_STATE
);

  // Handshake: a requester holds REQ/REQ_DATA/REQ_LAST stable until it sees its
  // one-cycle ACK; the byte is taken on the edge that raises ACK, and the
  // requester may present its next byte on the following edge.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TO_LAST = (LOCK_TIMEOUT > 0) ? TW'(LOCK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            guard_q, guard_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            locked_q, locked_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;

  // The pointer always names the last winner, so it doubles as the lock owner.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    if (locked_q) begin
      win_found = REQ[ptr_q];
      win_idx   = ptr_q;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        cand = (int'(ptr_q) + off) % NREQ;
        if (!win_found && REQ[cand]) begin
          win_found = 1'b1;
          win_idx   = cand[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    start_d  = start_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (!TX_BUSY && win_found) begin
          data_d   = REQ_DATA[8*int'(win_idx) +: 8];
          start_d  = 1'b1;
          ack_d    = NREQ'(1) << win_idx;
          grant_d  = NREQ'(1) << win_idx;
          ptr_d    = win_idx;
          locked_d = ~REQ_LAST[win_idx];
          cnt_d    = '0;
          state_d  = S_START;
        end else if (locked_q && (LOCK_TIMEOUT > 0)) begin
          if (REQ[ptr_q]) begin
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
      S_START: begin
        start_d = 1'b0;
        ack_d   = '0;
        guard_d = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // uart_tx may not have raised TX_BUSY yet on the first BUSY cycle.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!TX_BUSY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      guard_q  <= 1'b0;
      ptr_q    <= PW'(NREQ - 1);
      cnt_q    <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  assign ACK       = ack_q;
  assign GRANT     = grant_q;
  assign LOCKED    = locked_q;
  assign TX_START  = start_q;
  assign TX_DATA   = data_q;
  assign DBG_STATE = state_q;

endmodule
